// File: rtl/div_unit_pkg.sv
// div_unit_pkg: state codes, handshake levels and execute op codes shared with the divider
package div_unit_pkg;
  typedef enum logic [1:0] {DIV_FREE = 2'b00, DIV_BYZERO = 2'b01, DIV_ON = 2'b10, DIV_END = 2'b11} div_state_t;
  localparam logic DIV_START = 1'b1;
  localparam logic DIV_STOP = 1'b0;
  localparam logic DIV_RESULT_READY = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;
  localparam logic [7:0] EXE_DIV_OP = 8'b00011010;
  localparam logic [7:0] EXE_DIVU_OP = 8'b00011011;
endpackage

// File: rtl/div_unit.sv
// div_unit: radix-2 restoring 32-bit DIV/DIVU; in clk rst signed_div_i opdata1_i opdata2_i start_i annul_i, out result_o {rem,quo} ready_o
module div_unit
  import div_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        signed_div_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        start_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o
);
  div_state_t state;
  logic [5:0] cnt;
  logic [31:0] r, q, d, nr, nq, a1, a2;
  logic n1, n2;
  logic [32:0] t;
  always_comb begin
    t = {r, q[31]} - {1'b0, d};
    nr = t[32] ? {r[30:0], q[31]} : t[31:0];
    nq = {q[30:0], ~t[32]};
    a1 = (signed_div_i && opdata1_i[31]) ? -opdata1_i : opdata1_i;
    a2 = (signed_div_i && opdata2_i[31]) ? -opdata2_i : opdata2_i;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= DIV_FREE;
      ready_o <= DIV_RESULT_NOT_READY;
      result_o <= '0;
      cnt <= '0;
      r <= '0;
      q <= '0;
      d <= '0;
      n1 <= 1'b0;
      n2 <= 1'b0;
    end else begin
      case (state)
        DIV_FREE: begin
          ready_o <= DIV_RESULT_NOT_READY;
          result_o <= '0;
          if (start_i == DIV_START && !annul_i) begin
            n1 <= signed_div_i & opdata1_i[31];
            n2 <= signed_div_i & opdata2_i[31];
            q <= a1;
            d <= a2;
            r <= '0;
            cnt <= '0;
            state <= (opdata2_i == '0) ? DIV_BYZERO : DIV_ON;
          end
        end
        DIV_BYZERO: begin
          state <= annul_i ? DIV_FREE : DIV_END;
          ready_o <= annul_i ? DIV_RESULT_NOT_READY : DIV_RESULT_READY;
        end
        DIV_ON: begin
          if (annul_i) begin
            state <= DIV_FREE;
          end else begin
            r <= nr;
            q <= nq;
            cnt <= cnt + 6'd1;
            if (cnt == 6'd31) begin
              result_o <= {n1 ? -nr : nr, (n1 ^ n2) ? -nq : nq};
              ready_o <= DIV_RESULT_READY;
              state <= DIV_END;
            end
          end
        end
        DIV_END: begin
          if (start_i == DIV_STOP) begin
            state <= DIV_FREE;
            ready_o <= DIV_RESULT_NOT_READY;
            result_o <= '0;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed self-checking bench for div_unit with a cycle-level behavioural model
module tb_div_unit;
  logic clk = 1'b0;
  logic rst, signed_div, start, annul;
  logic [31:0] opdata1, opdata2;
  logic [63:0] result;
  logic ready;
  int errors = 0;
  int checks = 0;
  logic armed = 1'b0;
  logic m_busy = 1'b0;
  logic m_done = 1'b0;
  logic [63:0] m_res = '0;
  int m_age = 0;
  int m_lat = 0;

  div_unit dut (
    .clk(clk), .rst(rst), .signed_div_i(signed_div), .opdata1_i(opdata1),
    .opdata2_i(opdata2), .start_i(start), .annul_i(annul),
    .result_o(result), .ready_o(ready)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] exp_div(input logic [31:0] a, input logic [31:0] b, input logic s);
    int sq, sr;
    if (b == 0) return 64'd0;
    if (!s) return {a % b, a / b};
    if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'd0, 32'h80000000};
    sq = int'(a) / int'(b);
    sr = int'(a) % int'(b);
    return {sr, sq};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
    end else if (m_done) begin
      if (!start) m_done <= 1'b0;
    end else if (m_busy) begin
      if (annul) m_busy <= 1'b0;
      else begin
        m_age <= m_age + 1;
        if (m_age + 1 == m_lat - 1) begin
          m_busy <= 1'b0;
          m_done <= 1'b1;
        end
      end
    end else if (start && !annul) begin
      m_busy <= 1'b1;
      m_age <= 0;
      m_res <= exp_div(opdata1, opdata2, signed_div);
      m_lat <= (opdata2 == 0) ? 2 : 33;
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      chk("model_ready", {63'd0, ready}, {63'd0, m_done});
      chk("model_result", result, m_done ? m_res : 64'd0);
    end
  end

  task automatic run(input logic [31:0] a, input logic [31:0] b, input logic s,
                     input logic [63:0] exp, input int lat, input string nm);
    int n;
    @(posedge clk); #1;
    opdata1 = a; opdata2 = b; signed_div = s; start = 1'b1;
    @(posedge clk); #1;
    opdata1 = $urandom; opdata2 = $urandom; signed_div = ~s;
    n = 1;
    while (!ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk({nm, "_lat"}, 64'(n), 64'(lat));
    chk({nm, "_res"}, result, exp);
    repeat (5) @(posedge clk);
    #1;
    chk({nm, "_hold"}, result, exp);
    chk({nm, "_hold_rdy"}, {63'd0, ready}, 64'd1);
    start = 1'b0;
    @(posedge clk); #1;
    chk({nm, "_drop"}, {63'd0, ready}, 64'd0);
  endtask

  initial begin
    bit seen;
    rst = 1'b1; start = 1'b0; annul = 1'b0; signed_div = 1'b0;
    opdata1 = '0; opdata2 = '0;
    @(posedge clk); #1;
    armed = 1'b1;
    chk("reset_ready", {63'd0, ready}, 64'd0);
    chk("reset_result", result, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    chk("pin_udiv", exp_div(32'd100, 32'd7, 1'b0), 64'h00000002_0000000E);
    chk("pin_sdiv", exp_div(32'hFFFFFFF9, 32'd2, 1'b1), 64'hFFFFFFFF_FFFFFFFD);
    chk("pin_udiv2", exp_div(32'hFFFFFFF9, 32'd2, 1'b0), 64'h00000001_7FFFFFFC);
    chk("pin_ovf", exp_div(32'h80000000, 32'hFFFFFFFF, 1'b1), 64'h00000000_80000000);
    chk("pin_zero", exp_div(32'd5, 32'd0, 1'b1), 64'd0);
    run(32'd100, 32'd7, 1'b0, 64'h00000002_0000000E, 33, "udiv");
    run(32'hFFFFFFF9, 32'd2, 1'b1, 64'hFFFFFFFF_FFFFFFFD, 33, "sdiv");
    run(32'hFFFFFFF9, 32'd2, 1'b0, 64'h00000001_7FFFFFFC, 33, "udiv_big");
    run(32'd5, 32'd0, 1'b0, 64'd0, 2, "byzero");
    run(32'h80000000, 32'hFFFFFFFF, 1'b1, 64'h00000000_80000000, 33, "ovf");
    run(32'd7, 32'hFFFFFFFE, 1'b1, 64'h00000001_FFFFFFFD, 33, "sdiv_negd");
    run(32'hFFFFFFFF, 32'd1, 1'b0, 64'h00000000_FFFFFFFF, 33, "udiv_one");
    run(32'd3, 32'd10, 1'b0, 64'h00000003_00000000, 33, "udiv_small");
    @(posedge clk); #1;
    opdata1 = 32'd100; opdata2 = 32'd7; signed_div = 1'b0; start = 1'b1;
    for (int n = 1; n <= 10; n++) begin
      @(posedge clk); #1;
    end
    annul = 1'b1; start = 1'b0;
    @(posedge clk); #1;
    annul = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      seen |= ready;
      @(posedge clk); #1;
    end
    chk("annul_noready", {63'd0, seen}, 64'd0);
    run(32'd9, 32'd3, 1'b0, 64'h00000000_00000003, 33, "after_annul");
    @(posedge clk); #1;
    opdata1 = 32'd1000; opdata2 = 32'd10; signed_div = 1'b0; start = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
    end
    rst = 1'b1; start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_mid_ready", {63'd0, ready}, 64'd0);
    chk("rst_mid_result", result, 64'd0);
    run(32'd1000, 32'd10, 1'b1, 64'h00000000_00000064, 33, "after_rst");
    repeat (3) @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/div_unit.md
# div_unit

Multi-cycle 32-bit integer divider serving the execute stage as a responder for DIV/DIVU. Execute raises a start request with operands and holds it, stalling the pipeline, until the divider returns a 64-bit {remainder, quotient} result with a ready flag. Execute then writes the result to HI/LO. Radix-2 restoring algorithm, one quotient bit per cycle, with a cancel (annul) path for pipeline flushes.

## Interface

- Parameters: none; width fixed at 32 (RegBus) and 64 (DoubleRegBus).
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, synchronous, active-high
- signed_div_i  in  1  1 = DIV (signed), 0 = DIVU
- opdata1_i  in  32  dividend
- opdata2_i  in  32  divisor
- start_i  in  1  request from execute; held high until result consumed
- annul_i  in  1  cancel the in-flight division
- result_o  out  64  {remainder[63:32], quotient[31:0]}; registered
- ready_o  out  1  result valid; registered

## Operation

- States: FREE, BYZERO, ON, END. Reset → FREE, result_o = 0, ready_o = 0.
- FREE: if start_i=1 and annul_i=0: capture signed_div_i; capture |opdata1_i| and |opdata2_i| when signed, raw operands otherwise; capture the sign flags. Go to BYZERO if opdata2_i == 0, else ON with iteration count 0, R = 0, Q = captured dividend. Otherwise stay in FREE with ready_o = 0 and result_o = 0.
- Operands are sampled only in FREE. Later input changes are ignored.
- BYZERO: next cycle go to END with result_o = 0 and ready_o = 1. Divide-by-zero result is 0 by design.
- ON, per cycle:
  - T = {R, Q[31]} − {1'b0, D}, 33 bits.
  - If T[32] = 1 (negative): R = {R[30:0], Q[31]} and Q = {Q[30:0], 0}.
  - Else: R = T[31:0] and Q = {Q[30:0], 1}.
  - Increment count.
- On the 32nd iteration, register the sign-corrected result, set ready_o = 1 and go to END.
  - Signed, dividend sign ≠ divisor sign: negate the quotient.
  - Signed, dividend negative: negate the remainder.
  - Unsigned: no correction.
- END: hold result_o and ready_o while start_i = 1. When start_i = 0, go to FREE, ready_o = 0, result_o = 0.
- annul_i = 1 in ON or BYZERO: go to FREE next edge, ready_o = 0, result_o = 0, no result produced. In END, annul_i has no effect; start_i governs.
- Signed overflow: −2^31 / −1 gives quotient 0x80000000, remainder 0. This is the natural result of the unsigned core on magnitudes, with no special-casing.
- The sign of a zero result is irrelevant: negating 0 gives 0.

## Timing

- Cycle t0 = the cycle in which start_i is sampled high in FREE.
- Normal: iterations run on the edges ending t1..t32. ready_o is high from t33, i.e. 33 cycles after the request.
- Divide by zero: ready_o is high from t2.
- After start_i falls, ready_o is low on the next cycle. A new request can be accepted in the cycle after that, in FREE.
- rst asserted in any state → FREE with outputs zeroed at that edge. rst has priority over annul_i and start_i.
- Back-to-back DIV: execute must drop start_i for ≥1 cycle between operations. A start_i that stays high in END does not restart the divider.

## Structure

- Shared defines.v:
  - DivFree, DivByZero, DivOn, DivEnd (2-bit state codes)
  - DivStart / DivStop
  - DivResultReady / DivResultNotReady
  - EXE_DIV_OP / EXE_DIVU_OP
- Single module; no sub-module. The subtract/shift step is inline combinational logic.
- State, count (6 bits), R, Q, D and sign flags are the only registers.

## Test plan

- Unsigned: opdata1 = 100, opdata2 = 7, signed = 0 → at t33 ready_o = 1, result_o = 0x00000002_0000000E.
- Signed: opdata1 = 0xFFFFFFF9 (−7), opdata2 = 2 → result_o = 0xFFFFFFFF_FFFFFFFD (rem −1, quo −3). The same operands unsigned → quo 0x7FFFFFFC, rem 1.
- Divide by zero: opdata2 = 0 → ready_o = 1 at t2, result_o = 0.
- Overflow: 0x80000000 / 0xFFFFFFFF signed → result_o = 0x00000000_80000000.
- Annul: assert annul_i at t10 → FREE at t11, ready_o never rises. Then a new request 9/3 → quotient 3, remainder 0 at its own t33.
- Hold/release and reset: keep start_i high 5 cycles after ready_o → result stable. Drop start_i → ready_o = 0 next cycle. rst at t20 mid-divide → FREE, outputs 0, next request works.
